heater_bank_ctrl: RTL and testbench

//  Per-bank controller between the PS GPIO registers and an array of N heater channels.

---
 rtl/heater_bank_if.sv | 48 ++++
 rtl/heater_bank_ctrl.sv | 155 +++++++++++++++
 tb/tb_heater_bank_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/heater_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : heater_bank_if
// Description : Bundles the software-facing controls and heater-facing status
//               of one heater bank controller.
//               master : software / register side (drives requests, modes,
//                        heater error flags, clears; observes status)
//               slave  : heater_bank_ctrl (observes requests, drives status)
//               Signals:
//                 enable_req    [N]        per-channel enable request
//                 pwm_mode      [1]        0 = continuous, 1 = PWM throttled
//                 duty          [PWM_BITS] global PWM duty
//                 trip_en       [1]        error edge auto-disables channel
//                 heater_error  [N]        error flags from heater channels
//                 err_clear     [N]        per-channel sticky/trip clear
//                 heater_enable [N]        registered heater enables
//                 err_sticky    [N]        latched error flags
//                 err_total     [ERRCNT_W] saturating error-edge tally
//                 busy          [1]        requests pending, not yet granted
// Revision    : 1.0 - initial release
// ============================================================================
interface heater_bank_if #(
    parameter int N        = 32,
    parameter int PWM_BITS = 8,
    parameter int ERRCNT_W = 16
);
    logic [N-1:0]        enable_req;
    logic                pwm_mode;
    logic [PWM_BITS-1:0] duty;
    logic                trip_en;
    logic [N-1:0]        heater_error;
    logic [N-1:0]        err_clear;
    logic [N-1:0]        heater_enable;
    logic [N-1:0]        err_sticky;
    logic [ERRCNT_W-1:0] err_total;
    logic                busy;

    modport master (
        output enable_req, pwm_mode, duty, trip_en, heater_error, err_clear,
        input  heater_enable, err_sticky, err_total, busy
    );

    modport slave (
        input  enable_req, pwm_mode, duty, trip_en, heater_error, err_clear,
        output heater_enable, err_sticky, err_total, busy
    );
endinterface
`default_nettype wire

// File: rtl/heater_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : heater_bank_ctrl
// Description : Per-bank controller between software enable registers and N
//               heater channels. Grants channel turn-ons one at a time with a
//               fixed spacing of STAGGER clocks (lowest index first), applies
//               optional phase-spread PWM throttling, captures sticky
//               per-channel errors with optional auto-trip and keeps a
//               saturating tally of error rising edges.
//               Ports:
//                 clk  : heater clock
//                 rst  : asynchronous, active-high reset
//                 bus  : heater_bank_if.slave (requests, modes, errors in;
//                        heater_enable, err_sticky, err_total, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module heater_bank_ctrl #(
    parameter int N          = 32,
    parameter int STAGGER    = 256,
    parameter int PWM_BITS   = 8,
    parameter int PHASE_STEP = 8,
    parameter int ERRCNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    heater_bank_if.slave  bus
);

    localparam int CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int PC_W  = $clog2(N + 1);
    localparam int SUM_W = ((ERRCNT_W > PC_W) ? ERRCNT_W : PC_W) + 1;

    localparam logic [CNT_W-1:0]    C_CNT_LOAD = CNT_W'(STAGGER - 1);
    localparam logic [ERRCNT_W-1:0] C_ERR_MAX  = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [N-1:0]        r_grant;
    logic [N-1:0]        r_tripped;
    logic [N-1:0]        r_err_prev;
    logic [N-1:0]        r_sticky;
    logic [N-1:0]        r_enable;
    logic [ERRCNT_W-1:0] r_err_total;
    logic                r_busy;
    logic [PWM_BITS-1:0] r_phase;

    logic [N-1:0]        w_rise;
    logic [N-1:0]        w_trip_set;
    logic [N-1:0]        w_pend;
    logic [N-1:0]        w_pick;
    logic [N-1:0]        w_new_grant;
    logic                w_slot_open;
    logic [N-1:0]        w_on;
    logic [PC_W-1:0]     w_rise_cnt;
    logic [SUM_W-1:0]    w_sum;
    logic [ERRCNT_W-1:0] w_total_next;

    assign w_rise     = bus.heater_error & ~r_err_prev;
    assign w_trip_set = bus.trip_en ? w_rise : '0;
    assign w_pend     = bus.enable_req & ~r_grant & ~r_tripped;

    // Isolate the lowest set bit of the pending vector.
    assign w_pick = w_pend & (~w_pend + N'(1));

    // A turn-on slot is available when idle, or on the edge where the
    // stagger counter has run down to zero.
    assign w_slot_open = (r_state == S_IDLE) || (r_cnt == '0);
    assign w_new_grant = w_slot_open ? w_pick : '0;

    // ------------------------------------------------------------------
    // Grant sequencer. Disables (request low or trip) apply immediately in
    // any state; a grant picked on the same edge its channel trips is
    // cancelled by the trip but still consumes the stagger slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_grant <= (r_grant | w_new_grant) & bus.enable_req & ~w_trip_set;
            r_busy  <= |w_pend;
            if (w_slot_open) begin
                if (|w_pend) begin
                    r_state <= (STAGGER > 1) ? S_HOLD : S_IDLE;
                    r_cnt   <= C_CNT_LOAD;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM: each channel sees the shared phase counter shifted by its own
    // offset, so channel turn-on points are spread across the period.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_pwm
        logic [PWM_BITS-1:0] w_phase_ch;
        assign w_phase_ch = r_phase + PWM_BITS'(gi * PHASE_STEP);
        assign w_on[gi]   = (w_phase_ch < bus.duty);
    end

    // ------------------------------------------------------------------
    // Error tally: popcount of rising edges, then a saturating add done in
    // a wider width so overflow is visible before clamping.
    // ------------------------------------------------------------------
    always_comb begin
        w_rise_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_rise_cnt = w_rise_cnt + PC_W'(w_rise[i]);
        end
    end

    assign w_sum        = SUM_W'(r_err_total) + SUM_W'(w_rise_cnt);
    assign w_total_next = (w_sum > SUM_W'(C_ERR_MAX)) ? C_ERR_MAX
                                                      : w_sum[ERRCNT_W-1:0];

    // ------------------------------------------------------------------
    // Error capture, phase counter and output register. A rising edge and
    // a clear in the same cycle leave the flag set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_prev  <= '0;
            r_sticky    <= '0;
            r_tripped   <= '0;
            r_err_total <= '0;
            r_phase     <= '0;
            r_enable    <= '0;
        end else begin
            r_err_prev  <= bus.heater_error;
            r_sticky    <= (r_sticky & ~bus.err_clear) | w_rise;
            r_tripped   <= (r_tripped & ~bus.err_clear) | w_trip_set;
            r_err_total <= w_total_next;
            r_phase     <= r_phase + PWM_BITS'(1);
            r_enable    <= r_grant & (bus.pwm_mode ? w_on : '1);
        end
    end

    assign bus.heater_enable = r_enable;
    assign bus.err_sticky    = r_sticky;
    assign bus.err_total     = r_err_total;
    assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_heater_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_heater_bank_ctrl
// Description : Directed self-checking bench for heater_bank_ctrl
//               (N=32, STAGGER=4, PWM_BITS=8, PHASE_STEP=8, ERRCNT_W=2).
//               Inputs change on the falling clock edge; outputs are sampled
//               on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heater_bank_ctrl;

    localparam int N          = 32;
    localparam int STAGGER    = 4;
    localparam int PWM_BITS   = 8;
    localparam int PHASE_STEP = 8;
    localparam int ERRCNT_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc;

    heater_bank_if #(.N(N), .PWM_BITS(PWM_BITS), .ERRCNT_W(ERRCNT_W)) bus ();

    heater_bank_ctrl #(
        .N(N), .STAGGER(STAGGER), .PWM_BITS(PWM_BITS),
        .PHASE_STEP(PHASE_STEP), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release; the phase counter seen at
    // edge k is (k-1) mod 256.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Channels whose heater_enable is high after the n-th edge of a ramp:
    // channel k is granted on edge 1+STAGGER*k and shows one edge later.
    function automatic logic [N-1:0] ramp_mask(input int n);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) if (STAGGER * k + 2 <= n) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [N-1:0] pwm_mask(input int c, input int d);
        logic [N-1:0] m;
        int ph;
        m = '0;
        for (int i = 0; i < N; i++) begin
            ph   = (c - 1 + i * PHASE_STEP) % 256;
            m[i] = (ph < d);
        end
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.enable_req = '0; bus.pwm_mode = 1'b0; bus.duty = '0;
        bus.trip_en = 1'b0; bus.heater_error = '0; bus.err_clear = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.heater_enable !== '0) $display("FAIL reset_enable got %h want 0", bus.heater_enable); else n_pass++;
        n_total++;
        if (bus.err_sticky !== '0) $display("FAIL reset_sticky got %h want 0", bus.err_sticky); else n_pass++;
        n_total++;
        if (bus.err_total !== '0) $display("FAIL reset_total got %0d want 0", bus.err_total); else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        rst = 1'b0;
    endtask

    // Requests rise together right at reset release; the ramp runs to completion.
    task automatic test_ramp(input string tag);
        logic [N-1:0] e;
        bus.enable_req = '1;
        for (int n = 1; n <= 130; n++) begin
            @(negedge clk);
            e = ramp_mask(n);
            n_total++;
            if (bus.heater_enable !== e)
                $display("FAIL %s_enable n=%0d got %h want %h", tag, n, bus.heater_enable, e);
            else n_pass++;
            n_total++;
            if (bus.busy !== (n <= 125))
                $display("FAIL %s_busy n=%0d got %b want %b", tag, n, bus.busy, (n <= 125));
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        logic [N-1:0] e;
        e = '1; e[5] = 1'b0;
        bus.enable_req[5] = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.heater_enable !== '1) $display("FAIL drop_1clk got %h want %h", bus.heater_enable, {N{1'b1}}); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_total++;
            if (bus.heater_enable !== e) $display("FAIL drop_low k=%0d got %h want %h", k, bus.heater_enable, e); else n_pass++;
            n_total++;
            if (bus.busy !== 1'b0) $display("FAIL drop_busy k=%0d got %b want 0", k, bus.busy); else n_pass++;
        end
        bus.enable_req[5] = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.heater_enable !== e || bus.busy !== 1'b1)
            $display("FAIL regrant_edge got %h/%b want %h/1", bus.heater_enable, bus.busy, e);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.heater_enable !== '1 || bus.busy !== 1'b0)
            $display("FAIL regrant_on got %h/%b want all-ones/0", bus.heater_enable, bus.busy);
        else n_pass++;
    endtask

    task automatic test_pwm();
        logic [N-1:0] e;
        int c0, c1;
        bus.pwm_mode = 1'b1;
        bus.duty     = 8'd64;
        c0 = 0; c1 = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            e = pwm_mask(cyc, 64);
            n_total++;
            if (bus.heater_enable !== e)
                $display("FAIL pwm64 cyc=%0d got %h want %h", cyc, bus.heater_enable, e);
            else n_pass++;
            c0 += int'(bus.heater_enable[0]);
            c1 += int'(bus.heater_enable[1]);
        end
        n_total++;
        if (c0 !== 64) $display("FAIL pwm64_ch0_count got %0d want 64", c0); else n_pass++;
        n_total++;
        if (c1 !== 64) $display("FAIL pwm64_ch1_count got %0d want 64", c1); else n_pass++;

        bus.duty = 8'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if (bus.heater_enable !== '0) $display("FAIL pwm0 k=%0d got %h want 0", k, bus.heater_enable); else n_pass++;
        end

        bus.duty = 8'd255;
        c0 = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            c0 += int'(bus.heater_enable[0]);
        end
        n_total++;
        if (c0 !== 255) $display("FAIL pwm255_ch0_count got %0d want 255", c0); else n_pass++;

        bus.pwm_mode = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.heater_enable !== '1) $display("FAIL pwm_off got %h want all-ones", bus.heater_enable); else n_pass++;
    endtask

    task automatic test_trip();
        logic [N-1:0] e;
        e = '1; e[3] = 1'b0;
        bus.trip_en = 1'b1;
        bus.heater_error[3] = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.err_sticky !== 32'h0000_0008) $display("FAIL trip_sticky got %h want 00000008", bus.err_sticky); else n_pass++;
        n_total++;
        if (bus.err_total !== 2'd1) $display("FAIL trip_total got %0d want 1", bus.err_total); else n_pass++;
        n_total++;
        if (bus.heater_enable !== '1) $display("FAIL trip_same got %h want all-ones", bus.heater_enable); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_total++;
            if (bus.heater_enable !== e || bus.busy !== 1'b0)
                $display("FAIL trip_held k=%0d got %h/%b want %h/0", k, bus.heater_enable, bus.busy, e);
            else n_pass++;
        end
        bus.heater_error[3] = 1'b0;
        bus.err_clear[3]    = 1'b1;
        @(negedge clk);
        bus.err_clear = '0;
        n_total++;
        if (bus.err_sticky !== '0 || bus.heater_enable !== e)
            $display("FAIL clear_edge got %h/%h want 0/%h", bus.err_sticky, bus.heater_enable, e);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.heater_enable !== e || bus.busy !== 1'b1)
            $display("FAIL clear_regrant got %h/%b want %h/1", bus.heater_enable, bus.busy, e);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.heater_enable !== '1 || bus.busy !== 1'b0)
            $display("FAIL clear_on got %h/%b want all-ones/0", bus.heater_enable, bus.busy);
        else n_pass++;
        bus.trip_en = 1'b0;
    endtask

    task automatic test_reset_mid_ramp();
        logic [N-1:0] e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (37) @(negedge clk);
        e = ramp_mask(37);
        n_total++;
        if (bus.heater_enable !== e) $display("FAIL midramp_pre got %h want %h", bus.heater_enable, e); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (bus.heater_enable !== '0 || bus.busy !== 1'b0)
            $display("FAIL midramp_async got %h/%b want 0/0", bus.heater_enable, bus.busy);
        else n_pass++;
        n_total++;
        if (bus.err_total !== '0 || bus.err_sticky !== '0)
            $display("FAIL midramp_errs got %0d/%h want 0/0", bus.err_total, bus.err_sticky);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        test_ramp("reramp");
    endtask

    task automatic test_err_tally();
        bus.trip_en      = 1'b0;
        bus.heater_error = 32'h4000_0082;
        bus.err_clear    = 32'h0000_0080;
        @(negedge clk);
        bus.err_clear = '0;
        n_total++;
        if (bus.err_sticky !== 32'h4000_0082) $display("FAIL tally_sticky got %h want 40000082", bus.err_sticky); else n_pass++;
        n_total++;
        if (bus.err_total !== 2'd3) $display("FAIL tally_three got %0d want 3", bus.err_total); else n_pass++;
        n_total++;
        if (bus.heater_enable !== '1) $display("FAIL tally_notrip got %h want all-ones", bus.heater_enable); else n_pass++;
        bus.heater_error = '0;
        @(negedge clk);
        bus.heater_error[2] = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.err_total !== 2'd3) $display("FAIL tally_sat got %0d want 3", bus.err_total); else n_pass++;
        n_total++;
        if (bus.err_sticky !== 32'h4000_0086) $display("FAIL tally_sticky2 got %h want 40000086", bus.err_sticky); else n_pass++;
        bus.err_clear = '1;
        @(negedge clk);
        bus.err_clear = '0;
        n_total++;
        if (bus.err_sticky !== '0) $display("FAIL tally_clear got %h want 0", bus.err_sticky); else n_pass++;
        n_total++;
        if (bus.err_total !== 2'd3) $display("FAIL tally_keep got %0d want 3", bus.err_total); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp("ramp");
        test_drop();
        test_pwm();
        test_trip();
        test_reset_mid_ramp();
        test_err_tally();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
